// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port round-robin arbiter for a shared SRAM interface with conf sequencing
module sram_port_arbiter #(
    parameter int          READ_LAT = 3,
    parameter logic [2:0]  CONF_RST = 3'b101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [13:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_rvalid,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [13:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_rvalid,
    output logic [31:0] rdata,
    input  logic        cfg_valid,
    input  logic [2:0]  cfg_conf,
    output logic        cfg_ready,
    output logic        busy,
    output logic        csb_o,
    output logic        web_o,
    output logic [8:0]  addr_o,
    output logic [1:0]  addr24_o,
    output logic [2:0]  addr38_o,
    output logic [31:0] wdata_o,
    output logic [2:0]  conf_o,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t              state;
    logic                rr;          // port that wins when both request
    logic                issue_port;  // port owning the access currently on the pins
    logic [READ_LAT-1:0] trk_v;
    logic [READ_LAT-1:0] trk_p;
    logic                bus_read;
    logic                pending;
    logic                grant0;
    logic                grant1;
    logic                sel;
    logic                sel_we;
    logic [13:0]         sel_addr;
    logic [31:0]         sel_wdata;

    // A read is on the pins this cycle; it counts as in flight from this point on
    assign bus_read = ~csb_o & web_o;
    assign pending  = bus_read | (|trk_v);
    assign busy     = (state != S_RUN) | pending;

    assign rdata     = sram_rdata;
    assign p0_rvalid = trk_v[READ_LAT-1] & ~trk_p[READ_LAT-1];
    assign p1_rvalid = trk_v[READ_LAT-1] &  trk_p[READ_LAT-1];

    assign p0_ready = grant0;
    assign p1_ready = grant1;

    // Round-robin grant, suppressed whenever a configuration change is requested or underway
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == S_RUN && !cfg_valid) begin
            grant0 = p0_valid & (~p1_valid | ~rr);
            grant1 = p1_valid & (~p0_valid |  rr);
        end
    end

    // Fields of the granted request
    always_comb begin
        sel       = grant1;
        sel_we    = sel ? p1_we    : p0_we;
        sel_addr  = sel ? p1_addr  : p0_addr;
        sel_wdata = sel ? p1_wdata : p0_wdata;
    end

    // Registered interface pins: one access per grant, idle strobes otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb_o      <= 1'b1;
            web_o      <= 1'b1;
            addr_o     <= '0;
            addr24_o   <= '0;
            addr38_o   <= '0;
            wdata_o    <= '0;
            issue_port <= 1'b0;
            rr         <= 1'b0;
        end else if (grant0 || grant1) begin
            csb_o      <= 1'b0;
            web_o      <= ~sel_we;
            addr24_o   <= sel_addr[13:12];
            addr_o     <= sel_addr[11:3];
            addr38_o   <= sel_addr[2:0];
            wdata_o    <= sel_wdata;
            issue_port <= sel;
            rr         <= ~sel;
        end else begin
            csb_o <= 1'b1;
            web_o <= 1'b1;
        end
    end

    // Read tracker: tail entry lines up with sram_rdata READ_LAT cycles after the read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_v <= '0;
            trk_p <= '0;
        end else begin
            trk_v[0] <= bus_read;
            trk_p[0] <= issue_port;
            for (int i = 1; i < READ_LAT; i++) begin
                trk_v[i] <= trk_v[i-1];
                trk_p[i] <= trk_p[i-1];
            end
        end
    end

    // Configuration sequencer: stop granting, let reads finish under the old conf, then switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            conf_o    <= CONF_RST;
            cfg_ready <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    cfg_ready <= 1'b0;
                    if (cfg_valid) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!pending) begin
                        state     <= S_APPLY;
                        conf_o    <= cfg_conf;
                        cfg_ready <= 1'b1;
                    end
                end
                S_APPLY: begin
                    state     <= S_RUN;
                    cfg_ready <= 1'b0;
                end
                default: begin
                    state     <= S_RUN;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
